// File: rtl/icache_refill_unit.sv
// icache_refill_unit: fetches one cache line word-by-word from the memory bus on an icache miss
// and hands each word to the fetch unit as a one-cycle word_ready pulse.
module icache_refill_unit #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              miss_cache,
    input  logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] mem_word,
    output logic              word_ready,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [WORD_W-1:0] bus_rdata,
    output logic              busy
);
    localparam int CW = $clog2(LINE_WORDS);
    localparam int OFF = CW + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF) - 1);
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] mem_word_q, mem_word_d;
    logic              word_ready_q, word_ready_d;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            mem_word_q   <= '0;
            word_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            mem_word_q   <= mem_word_d;
            word_ready_q <= word_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        mem_word_d   = mem_word_q;
        word_ready_d = 1'b0;
        case (state_q)
            S_IDLE: if (miss_cache) begin
                base_d  = ram_address & ~LINE_MASK;
                cnt_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: state_d = bus_gnt ? S_WAIT : (miss_cache ? S_REQ : S_IDLE);
            // An aborted refill still drains its outstanding beat, but silently.
            S_WAIT: if (bus_rvalid) begin
                if (!miss_cache) state_d = S_IDLE;
                else begin
                    mem_word_d   = bus_rdata;
                    word_ready_d = 1'b1;
                    cnt_d        = cnt_q + CW'(1);
                    state_d      = (cnt_q == LAST) ? S_DONE : S_REQ;
                end
            end
            S_DONE: state_d = miss_cache ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_addr   = base_q | ADDR_W'({cnt_q, 2'b00});
    assign bus_req    = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign mem_word   = mem_word_q;
    assign word_ready = word_ready_q;
endmodule
